// File: rtl/assoc_refill_controller_if.sv
// Requester / associative-block / memory signal bundle for the refill controller.
// Latency: none (wires only).
// Backpressure: valid/ready on req, resp and mem_req; lookup, fill and mem_resp have no backpressure.
interface assoc_refill_controller_if #(
    parameter int BITS_DATA    = 32,
    parameter int BITS_ADDRESS = 32,
    parameter int WAY_BITS     = 1
);
    logic                    req_valid;
    logic                    req_ready;
    logic [BITS_ADDRESS-1:0] req_address;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [BITS_DATA-1:0]    resp_data;
    logic                    resp_hit;
    logic [BITS_ADDRESS-1:0] lookup_address;
    logic                    lookup_hit;
    logic [BITS_DATA-1:0]    lookup_data;
    logic [WAY_BITS-1:0]     victim_way;
    logic                    fill_valid;
    logic [WAY_BITS-1:0]     fill_way;
    logic [BITS_ADDRESS-1:0] fill_address;
    logic [BITS_DATA-1:0]    fill_data;
    logic                    mem_req_valid;
    logic                    mem_req_ready;
    logic [BITS_ADDRESS-1:0] mem_req_address;
    logic                    mem_resp_valid;
    logic [BITS_DATA-1:0]    mem_resp_data;

    // Controller side.
    modport master (
        input  req_valid, req_address, resp_ready, lookup_hit, lookup_data, victim_way,
               mem_req_ready, mem_resp_valid, mem_resp_data,
        output req_ready, resp_valid, resp_data, resp_hit, lookup_address,
               fill_valid, fill_way, fill_address, fill_data, mem_req_valid, mem_req_address
    );

    // Requester / block / memory side.
    modport slave (
        output req_valid, req_address, resp_ready, lookup_hit, lookup_data, victim_way,
               mem_req_ready, mem_resp_valid, mem_resp_data,
        input  req_ready, resp_valid, resp_data, resp_hit, lookup_address,
               fill_valid, fill_way, fill_address, fill_data, mem_req_valid, mem_req_address
    );
endinterface

// File: rtl/assoc_refill_controller.sv
// Miss handler: lookup, on miss fetch from memory and fill victim way, then respond (ASSOC_REFILL_STATS_EN adds hit/miss counters).
// Latency: hit 1 cycle in LOOKUP then respond; miss adds memory request, memory wait and one fill cycle.
// Backpressure: one request in flight; req_ready only in IDLE; mem_req and resp held stable until accepted.
module assoc_refill_controller #(
    parameter int BITS_DATA     = 32,
    parameter int BITS_ADDRESS  = 32,
    parameter int ASSOCIATIVITY = 2,
    localparam int WAY_BITS     = (ASSOCIATIVITY > 1) ? $clog2(ASSOCIATIVITY) : 1
) (
    input  logic clock,
    input  logic reset,
    assoc_refill_controller_if.master bus
`ifdef ASSOC_REFILL_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        MEM_REQ  = 3'd2,
        MEM_WAIT = 3'd3,
        FILL     = 3'd4,
        RESPOND  = 3'd5
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [BITS_ADDRESS-1:0] addr_q;
    logic [BITS_DATA-1:0]    data_q;
    logic [WAY_BITS-1:0]     way_q;
    logic                    hit_q;

    // State register; reset always lands in IDLE, abandoning any memory request.
    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; memory responses are only looked at in MEM_WAIT.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (bus.req_valid)      state_next = LOOKUP;
            LOOKUP:   state_next = bus.lookup_hit ? RESPOND : MEM_REQ;
            MEM_REQ:  if (bus.mem_req_ready)  state_next = MEM_WAIT;
            MEM_WAIT: if (bus.mem_resp_valid) state_next = FILL;
            FILL:     state_next = RESPOND;
            RESPOND:  if (bus.resp_ready)     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Strobes owned by individual states.
    always_comb begin
        bus.req_ready     = (state == IDLE);
        bus.mem_req_valid = (state == MEM_REQ);
        bus.fill_valid    = (state == FILL);
        bus.resp_valid    = (state == RESPOND);
    end

    // Transaction registers: address at accept, hit data or way at lookup, refill data from memory.
    always_ff @(posedge clock) begin
        if (!reset) begin
            addr_q <= '0;
            data_q <= '0;
            way_q  <= '0;
            hit_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) addr_q <= bus.req_address;
                LOOKUP: begin
                    hit_q <= bus.lookup_hit;
                    if (bus.lookup_hit) data_q <= bus.lookup_data;
                    else                way_q  <= bus.victim_way;
                end
                MEM_WAIT: if (bus.mem_resp_valid) data_q <= bus.mem_resp_data;
                default: ;
            endcase
        end
    end

    // Every address-like output is the latched request; data outputs hold their last value.
    assign bus.lookup_address  = addr_q;
    assign bus.mem_req_address = addr_q;
    assign bus.fill_address    = addr_q;
    assign bus.fill_data       = data_q;
    assign bus.fill_way        = way_q;
    assign bus.resp_data       = data_q;
    assign bus.resp_hit        = hit_q;

`ifdef ASSOC_REFILL_STATS_EN
    // Saturating hit/miss counters, stepped on the single LOOKUP cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == LOOKUP) begin
            if (bus.lookup_hit) begin
                if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
            end else begin
                if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule
